tpu_result_checker: RTL
=======================

Name: tpu_result_checker

Overview:
Hardware self-check engine for the systolic-array TPU, parametrised in array size and batch count. After tpu_top finishes, it walks every diagonal-ordered result word of every batch. For each word it reads the result SRAM and a golden SRAM in lockstep and compares them lane by lane. It reports pass/fail, the error count and the location of the first mismatch, which moves the batch-vs-golden check from simulation into silicon/FPGA bring-up.

Parameters:
ARRAY_SIZE, 8, systolic array dimension N; each batch holds 2N-1 diagonal words
OUT_DATA_WIDTH, 16, bits per result lane; each word is N lanes
NUM_BATCH, 3, number of result batches (one result SRAM bank per batch)
ADDR_WIDTH, 6, result/golden SRAM address width; must satisfy 2^ADDR_WIDTH >= 2N-1
BSEL_WIDTH, 2, batch-select width; must satisfy 2^BSEL_WIDTH >= NUM_BATCH
ERR_WIDTH, 16, error counter width (saturating)

Ports:
clk  input  1  system clock, all logic rising-edge
srstn  input  1  synchronous active-low reset
chk_start  input  1  one-cycle start pulse; ignored unless idle
cmp_valid_only  input  1  mode: 1 = compare only valid diagonal lanes; 0 = compare all N lanes
stop_on_first  input  1  mode: 1 = abort scan at first mismatching word
sram_rsel  output  BSEL_WIDTH  batch/bank select for both result and golden reads
sram_raddr_r  output  ADDR_WIDTH  result SRAM read address
sram_rdata_r  input  ARRAY_SIZE*OUT_DATA_WIDTH  result SRAM read data
sram_raddr_g  output  ADDR_WIDTH  golden SRAM read address (always equal to sram_raddr_r)
sram_rdata_g  input  ARRAY_SIZE*OUT_DATA_WIDTH  golden SRAM read data
chk_busy  output  1  high from the start-accept edge until chk_done
chk_done  output  1  one-cycle pulse; result outputs are valid from this cycle
chk_pass  output  1  1 = zero mismatching words in the last completed scan
err_cnt  output  ERR_WIDTH  number of mismatching words; saturates at all-ones
first_err_bsel  output  BSEL_WIDTH  batch of the first mismatch
first_err_addr  output  ADDR_WIDTH  address of the first mismatch
first_err_lane  output  log2(ARRAY_SIZE) (min 1)  lowest mismatching lane of the first mismatch; lane 0 = MSB lane

Behaviour:
- Reset (srstn=0 at an edge): all outputs and internal state go to 0, FSM to IDLE. This holds mid-scan: the scan is abandoned, no chk_done is produced, and in-flight reads are discarded.
- SRAM model: synchronous read. An address registered at edge e is captured by the SRAM at edge e+1. Data is valid after e+1 and compared at edge e+2.
- Scan order: batch 0, address 0..2N-2, then batch 1, and so on. Total words E = NUM_BATCH*(2N-1).
- FSM states:
  - IDLE: on chk_start go to ISSUE at that edge. Address (0,0) is registered, err_cnt, first_err_* and chk_pass are cleared, chk_busy is set.
  - ISSUE: each edge advances the address. When address reaches 2N-2, it wraps to 0 and sram_rsel increments. After issuing the last word (edge E-1, counting the start edge as 0), go to DRAIN.
  - DRAIN: waits for the 2-stage read pipeline to empty. The last compare occurs at edge E+1. At that edge go to DONE.
  - DONE: chk_done=1 for exactly one cycle, chk_busy=0, chk_pass=(err_cnt==0). Return to IDLE at the next edge.
- Done timing: N=8, B=3 gives E=45, so chk_done is high in the cycle after edge 46.
- Valid-lane mask for address k: count = k+1 if k<N, else 2N-1-k. Lanes 0..count-1 (MSB side) are valid.
  - cmp_valid_only=1: invalid lanes are ignored.
  - cmp_valid_only=0: all lanes are compared.
- A word mismatches if any compared lane differs, bitwise. err_cnt increments by 1 per mismatching word and saturates.
- first_err_* is latched only at the first mismatch of a scan.
- stop_on_first=1: at the first mismatch compare edge, jump directly to DONE. Outstanding reads are dropped and err_cnt=1.
- A compare-pipeline tag (batch, addr, mask) travels alongside each read so that the reported location matches the data that was compared.
- chk_start while busy is ignored. A chk_start in the DONE cycle is also ignored.
- cmp_valid_only and stop_on_first are sampled at the start edge and held for the whole scan.
- Results hold until the next accepted start or reset.

Test Plan:
- Identical result and golden banks (N=8, B=3, both modes) -> chk_done after 46 edges, chk_pass=1, err_cnt=0.
- Result batch 1 addr 7, lane 3 corrupted (+1) -> chk_pass=0, err_cnt=1, first_err=(1,7,3).
- Garbage placed only in invalid lanes (batch 0 addr 0, lanes 1..7): cmp_valid_only=1 -> pass; cmp_valid_only=0 -> err_cnt=1, first_err=(0,0,1).
- Mismatches at (0,2), (2,14), (2,0) with stop_on_first=1 -> done early, err_cnt=1, first_err_addr=2. Same mismatches with stop_on_first=0 -> err_cnt=3, first_err=(0,2).
- srstn low during ISSUE at address 5, then restart -> no chk_done before the restart; after the restart, a full 46-edge scan with correct results. A second chk_start during the scan has no effect.
- Parameter sweep N=4, B=1 -> E=7, chk_done after 8 edges. Address sequence 0..6 on both ports with rsel=0.

Source files
------------

// File: rtl/tpu_result_checker_if.sv
// rtl/tpu_result_checker_if.sv - result/golden SRAM read bus between the checker and its memories
interface tpu_result_checker_if #(
  parameter int ARRAY_SIZE     = 8,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH     = 6,
  parameter int BSEL_WIDTH     = 2
);
  logic [BSEL_WIDTH-1:0]                sram_rsel;
  logic [ADDR_WIDTH-1:0]                sram_raddr_r;
  logic [ADDR_WIDTH-1:0]                sram_raddr_g;
  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_r;
  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_g;

  modport master (
    output sram_rsel, sram_raddr_r, sram_raddr_g,
    input  sram_rdata_r, sram_rdata_g
  );

  modport slave (
    input  sram_rsel, sram_raddr_r, sram_raddr_g,
    output sram_rdata_r, sram_rdata_g
  );
endinterface

// File: rtl/tpu_result_checker.sv
// rtl/tpu_result_checker.sv - scans every diagonal result word against golden SRAM and reports mismatches
module tpu_result_checker #(
  parameter int ARRAY_SIZE     = 8,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int NUM_BATCH      = 3,
  parameter int ADDR_WIDTH     = 6,
  parameter int BSEL_WIDTH     = 2,
  parameter int ERR_WIDTH      = 16,
  localparam int LANE_WIDTH    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  chk_start,
  input  logic                  cmp_valid_only,
  input  logic                  stop_on_first,
  tpu_result_checker_if.master  sram,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic                  chk_pass,
  output logic [ERR_WIDTH-1:0]  err_cnt,
  output logic [BSEL_WIDTH-1:0] first_err_bsel,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [LANE_WIDTH-1:0] first_err_lane
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = ADDR_WIDTH + 1;
  localparam int W  = OUT_DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(2*ARRAY_SIZE-2);
  localparam logic [BSEL_WIDTH-1:0] LAST_BSEL = BSEL_WIDTH'(NUM_BATCH-1);
  localparam bit ONE_WORD = (NUM_BATCH == 1) && (ARRAY_SIZE == 1);

  logic [1:0]            state_q;
  logic [BSEL_WIDTH-1:0] bsel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  addr_vld_q;
  logic                  mode_vo_q;
  logic                  mode_sof_q;

  // Tag of the word whose read data is on sram_rdata_* this cycle.
  logic                  tag_vld_q;
  logic [BSEL_WIDTH-1:0] tag_bsel_q;
  logic [ADDR_WIDTH-1:0] tag_addr_q;
  logic [ARRAY_SIZE-1:0] tag_mask_q;

  logic [CW-1:0]         valid_cnt;
  logic [ARRAY_SIZE-1:0] issue_mask;
  logic [ARRAY_SIZE-1:0] lane_diff;
  logic [LANE_WIDTH-1:0] bad_lane;
  logic                  word_bad;
  logic [ERR_WIDTH-1:0]  err_inc;
  logic                  addr_wrap;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [BSEL_WIDTH-1:0] nxt_bsel;
  logic                  nxt_is_last;
  logic                  finish;

  assign sram.sram_rsel    = bsel_q;
  assign sram.sram_raddr_r = addr_q;
  assign sram.sram_raddr_g = addr_q;

  // Diagonal k carries k+1 lanes on the rising half and 2N-1-k on the falling half.
  always_comb begin
    valid_cnt  = '0;
    issue_mask = '0;
    if ({1'b0, addr_q} < CW'(ARRAY_SIZE))
      valid_cnt = {1'b0, addr_q} + CW'(1);
    else
      valid_cnt = CW'(2*ARRAY_SIZE-1) - {1'b0, addr_q};
    for (int i = 0; i < ARRAY_SIZE; i++)
      issue_mask[i] = CW'(i) < valid_cnt;
  end

  // Lane 0 is the MSB lane; the descending scan leaves the lowest mismatching lane.
  always_comb begin
    lane_diff = '0;
    bad_lane  = '0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      lane_diff[i] = (sram.sram_rdata_r[(ARRAY_SIZE-1-i)*W +: W] !=
                      sram.sram_rdata_g[(ARRAY_SIZE-1-i)*W +: W]) &&
                     (tag_mask_q[i] || !mode_vo_q);
    for (int i = ARRAY_SIZE-1; i >= 0; i--)
      if (lane_diff[i]) bad_lane = LANE_WIDTH'(i);
  end

  assign word_bad    = tag_vld_q && (|lane_diff);
  assign err_inc     = (err_cnt == {ERR_WIDTH{1'b1}}) ? err_cnt : err_cnt + ERR_WIDTH'(1);
  assign addr_wrap   = (addr_q == LAST_ADDR);
  assign nxt_addr    = addr_wrap ? '0 : addr_q + ADDR_WIDTH'(1);
  assign nxt_bsel    = addr_wrap ? bsel_q + BSEL_WIDTH'(1) : bsel_q;
  assign nxt_is_last = (nxt_bsel == LAST_BSEL) && (nxt_addr == LAST_ADDR);
  assign finish      = ((state_q == S_DRAIN) && !addr_vld_q && tag_vld_q) ||
                       (word_bad && mode_sof_q);

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q        <= S_IDLE;
      bsel_q         <= '0;
      addr_q         <= '0;
      addr_vld_q     <= 1'b0;
      mode_vo_q      <= 1'b0;
      mode_sof_q     <= 1'b0;
      tag_vld_q      <= 1'b0;
      tag_bsel_q     <= '0;
      tag_addr_q     <= '0;
      tag_mask_q     <= '0;
      chk_busy       <= 1'b0;
      chk_done       <= 1'b0;
      chk_pass       <= 1'b0;
      err_cnt        <= '0;
      first_err_bsel <= '0;
      first_err_addr <= '0;
      first_err_lane <= '0;
    end else begin
      tag_vld_q  <= addr_vld_q;
      tag_bsel_q <= bsel_q;
      tag_addr_q <= addr_q;
      tag_mask_q <= issue_mask;
      chk_done   <= 1'b0;

      // err_cnt stays nonzero once set, so zero marks the first mismatch of the scan.
      if (word_bad) begin
        err_cnt <= err_inc;
        if (err_cnt == '0) begin
          first_err_bsel <= tag_bsel_q;
          first_err_addr <= tag_addr_q;
          first_err_lane <= bad_lane;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (chk_start) begin
            state_q        <= ONE_WORD ? S_DRAIN : S_ISSUE;
            bsel_q         <= '0;
            addr_q         <= '0;
            addr_vld_q     <= 1'b1;
            mode_vo_q      <= cmp_valid_only;
            mode_sof_q     <= stop_on_first;
            chk_busy       <= 1'b1;
            chk_pass       <= 1'b0;
            err_cnt        <= '0;
            first_err_bsel <= '0;
            first_err_addr <= '0;
            first_err_lane <= '0;
          end
        end
        S_ISSUE: begin
          addr_q <= nxt_addr;
          bsel_q <= nxt_bsel;
          if (nxt_is_last) state_q <= S_DRAIN;
        end
        S_DRAIN: addr_vld_q <= 1'b0;
        default: state_q <= S_IDLE;
      endcase

      // An early stop drops the reads still in flight.
      if (finish) begin
        state_q    <= S_DONE;
        addr_vld_q <= 1'b0;
        tag_vld_q  <= 1'b0;
        chk_done   <= 1'b1;
        chk_busy   <= 1'b0;
        chk_pass   <= !word_bad && (err_cnt == '0);
      end
    end
  end

endmodule
